conv_window_3x3: RTL and testbench
==================================

Name: conv_window_3x3

Overview:
- Sits directly downstream of the two chained line-delay buffers in the convolution front end.
- Takes three vertically aligned 64-bit pixel words per cycle: the current row plus the one-line-delayed and two-line-delayed taps.
- Assembles them into a 3x3 spatial window (9 x 64 bits) for the MAC array.
- Tracks row/column position, applies valid-convolution border rules and stride 1 or 2, and flags the last window of each frame.

Parameters:
- DATA_W, 64, bits per pixel word (8 channels x 8 bit).
- DIM_W, 16, width of dimension and position counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cfg_width  in  DIM_W  image width in pixel words.
- cfg_height  in  DIM_W  image height in rows.
- cfg_stride2  in  1  0 = stride 1, 1 = stride 2.
- in_valid  in  1  taps valid this cycle.
- in_row0  in  DATA_W  current-row word.
- in_row1  in  DATA_W  word from one line earlier.
- in_row2  in  DATA_W  word from two lines earlier.
- win_data  out  9*DATA_W  window; element (r,c) at bits [(r*3+c)*DATA_W +: DATA_W]. r=0 is the top row (in_row2), c=0 is the leftmost (oldest) column.
- win_valid  out  1  window valid, single-cycle pulse.
- win_last  out  1  high with the final window of the frame.
- win_row  out  DIM_W  window top-left row (see Optional Feature).
- win_col  out  DIM_W  window top-left column (see Optional Feature).
- busy  out  1  frame in progress.

Behaviour:
- Reset: all outputs 0; counters col and row 0; column shift registers 0; config latches 0; busy 0.
- Config latch: cfg_* is captured on the first in_valid while busy=0. That cycle sets busy=1. Config changes mid-frame are ignored.
- Per in_valid (including the latching cycle):
  - Column registers shift: c0->c1->c2. c0 loads {in_row2, in_row1, in_row0}.
  - col increments. At col == width-1, col wraps to 0 and row increments.
  - At row == height-1 and col == width-1, row and col return to 0 and busy clears on the following clock edge.
- No in_valid: nothing changes. Gaps in the input stream are allowed at any position.
- Emit condition, evaluated on the pre-increment col/row of the accepted word:
  - col >= 2 and row >= 2;
  - if stride2, additionally (col-2) and (row-2) are both even.
- Output timing: win_data, win_valid and win_last are registered, so latency is 1 cycle after the accepted word. win_valid deasserts the next cycle unless another emit occurs.
- win_last: emit condition AND col == width-1 AND row == height-1. For stride 2 with even width or height the final position is not an emit point, so no win_last pulse occurs. This is specified behaviour.
- Degenerate size: width < 3 or height < 3 produces no windows. Counters and busy still track the frame.
- Window contents at an emit: c2 (oldest) is column col-2, c0 (newest) is column col. Row 0 = row-2, row 2 = row.
- Reset mid-frame: abandons the frame. The next in_valid latches new config at position (0,0).
- No backpressure: the consumer must accept every win_valid pulse.
- Arithmetic: counters are DIM_W wide and unsigned. Compare width-1 computed in DIM_W; width=0 is treated as a degenerate size.

Optional Feature:
- Macro: WIN_COORD_EN.
- Defined: win_row/win_col are registered with win_data and equal (row-2, col-2) of the emitting word.
- Undefined: win_row/win_col are constant 0 and no coordinate registers are synthesised.
- All other behaviour is identical.

Decomposition:
- Shared package conv_pkg:
  - DATA_W, DIM_W, WIN_TAPS=9 constants;
  - typedef pix_t (logic [DATA_W-1:0]);
  - typedef win_t (pix_t array [9]);
  - function win_idx(r,c) returning r*3+c.
- One sub-module, win_pos_counter: col/row counters, busy, config latch, and emit/last decode.
- The top module holds the column shift registers and the output registers.

Test Plan:
- Stride 1 raster: width=4, height=4, in_row0 = row*16+col, in_row1/in_row2 = that value minus 16/32, continuous valid -> exactly 4 win_valid pulses. First win_data (0,0) = 0x00 and (2,2) = 0x22. win_last only on the 4th pulse.
- Stride 2: width=5, height=5 -> 4 windows at top-left (0,0), (0,2), (2,0), (2,2). win_last on the (2,2) window. Check win_row/win_col with WIN_COORD_EN defined.
- Stride 2 with even dims: width=6, height=6 -> 4 windows and no win_last pulse.
- Random in_valid gaps (50% duty) on the stride-1 case -> identical window sequence. Each win_valid is exactly 1 cycle after its completing in_valid.
- Degenerate and config-change cases:
  - width=2, height=8 -> zero windows; busy drops after 16 accepted words.
  - Changing cfg_width mid-frame has no effect.
- Reset mid-frame after 7 words, then a new frame with width=3, height=3 -> exactly one window, with win_last asserted. Contains no data from before reset.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window front end.
package conv_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned DIM_W    = 16;
  localparam int unsigned WIN_TAPS = 9;
  localparam int unsigned WIN_W    = WIN_TAPS * DATA_W;

  typedef logic [DATA_W-1:0] pix_t;
  typedef pix_t              win_t [WIN_TAPS];
  typedef logic [DIM_W-1:0]  dim_t;

  // Flat tap index of window element (r,c), r = row from top, c = column from oldest.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return r * 3 + c;
  endfunction

endpackage

// File: rtl/conv_window_3x3_if.sv
// Pixel-tap input, frame configuration and window output bundle of conv_window_3x3.
interface conv_window_3x3_if;
  import conv_pkg::*;

  dim_t             cfg_width;
  dim_t             cfg_height;
  logic             cfg_stride2;
  logic             in_valid;
  pix_t             in_row0;
  pix_t             in_row1;
  pix_t             in_row2;
  logic [WIN_W-1:0] win_data;
  logic             win_valid;
  logic             win_last;
  dim_t             win_row;
  dim_t             win_col;
  logic             busy;

  modport master (
    output cfg_width, cfg_height, cfg_stride2, in_valid, in_row0, in_row1, in_row2,
    input  win_data, win_valid, win_last, win_row, win_col, busy
  );

  modport slave (
    input  cfg_width, cfg_height, cfg_stride2, in_valid, in_row0, in_row1, in_row2,
    output win_data, win_valid, win_last, win_row, win_col, busy
  );

endinterface

// File: rtl/win_pos_counter.sv
// Row/column position tracking, per-frame config latch and window emit/last decode.
// With WIN_COORD_EN defined the current position is exported for coordinate tagging.
module win_pos_counter
  import conv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  dim_t cfg_width,
  input  dim_t cfg_height,
  input  logic cfg_stride2,
  output logic busy,
  output logic emit_c,
  output logic last_c
`ifdef WIN_COORD_EN
  ,
  output dim_t pos_row,
  output dim_t pos_col
`endif
);

  dim_t width_q, height_q;
  logic stride2_q;
  dim_t row_q, col_q;

  dim_t width_e, height_e;
  logic stride2_e;
  logic col_end_c, frame_end_c, degen_c;

  // The latching word itself must already see the incoming config.
  always_comb begin
    width_e     = busy ? width_q   : cfg_width;
    height_e    = busy ? height_q  : cfg_height;
    stride2_e   = busy ? stride2_q : cfg_stride2;
    col_end_c   = (col_q == width_e - dim_t'(1));
    frame_end_c = col_end_c && (row_q == height_e - dim_t'(1));
    degen_c     = (width_e < dim_t'(3)) || (height_e < dim_t'(3));
    emit_c      = 1'b0;
    last_c      = 1'b0;
    // (col-2) and (row-2) share parity with col and row.
    if (!degen_c && col_q >= dim_t'(2) && row_q >= dim_t'(2) &&
        (!stride2_e || (!col_q[0] && !row_q[0]))) begin
      emit_c = 1'b1;
      last_c = frame_end_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      width_q   <= '0;
      height_q  <= '0;
      stride2_q <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      busy      <= 1'b0;
    end else if (in_valid) begin
      if (!busy) begin
        width_q   <= cfg_width;
        height_q  <= cfg_height;
        stride2_q <= cfg_stride2;
      end
      if (frame_end_c) begin
        row_q <= '0;
        col_q <= '0;
        busy  <= 1'b0;
      end else begin
        busy <= 1'b1;
        if (col_end_c) begin
          col_q <= '0;
          row_q <= row_q + dim_t'(1);
        end else begin
          col_q <= col_q + dim_t'(1);
        end
      end
    end
  end

`ifdef WIN_COORD_EN
  assign pos_row = row_q;
  assign pos_col = col_q;
`endif

endmodule

// File: rtl/conv_window_3x3.sv
// 3x3 window assembler: column history plus registered window, valid/last and coordinates.
// Macro WIN_COORD_EN enables registered win_row/win_col; otherwise they are tied to 0.
module conv_window_3x3
  import conv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  conv_window_3x3_if.slave   bus
);

  logic busy_w, emit_c, last_c;
  pix_t new_col_c [3];
  pix_t c0_q      [3];
  pix_t c1_q      [3];
  win_t win_c;
  logic [WIN_W-1:0] win_flat_c;

`ifdef WIN_COORD_EN
  dim_t pos_row, pos_col;
`endif

  win_pos_counter u_pos (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (bus.in_valid),
    .cfg_width   (bus.cfg_width),
    .cfg_height  (bus.cfg_height),
    .cfg_stride2 (bus.cfg_stride2),
    .busy        (busy_w),
    .emit_c      (emit_c),
    .last_c      (last_c)
`ifdef WIN_COORD_EN
    ,
    .pos_row     (pos_row),
    .pos_col     (pos_col)
`endif
  );

  assign bus.busy = busy_w;

  // Window columns: oldest from c1_q, middle from c0_q, newest straight from the taps.
  always_comb begin
    new_col_c[0] = bus.in_row2;
    new_col_c[1] = bus.in_row1;
    new_col_c[2] = bus.in_row0;
    win_flat_c   = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      win_c[win_idx(r, 0)] = c1_q[r];
      win_c[win_idx(r, 1)] = c0_q[r];
      win_c[win_idx(r, 2)] = new_col_c[r];
    end
    for (int unsigned i = 0; i < WIN_TAPS; i++) begin
      win_flat_c[i*DATA_W +: DATA_W] = win_c[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c0_q          <= '{default: '0};
      c1_q          <= '{default: '0};
      bus.win_data  <= '0;
      bus.win_valid <= 1'b0;
      bus.win_last  <= 1'b0;
    end else begin
      bus.win_valid <= bus.in_valid && emit_c;
      bus.win_last  <= bus.in_valid && last_c;
      if (bus.in_valid) begin
        c1_q <= c0_q;
        c0_q <= new_col_c;
        if (emit_c) bus.win_data <= win_flat_c;
      end
    end
  end

`ifdef WIN_COORD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.win_row <= '0;
      bus.win_col <= '0;
    end else if (bus.in_valid && emit_c) begin
      bus.win_row <= pos_row - dim_t'(2);
      bus.win_col <= pos_col - dim_t'(2);
    end
  end
`else
  assign bus.win_row = '0;
  assign bus.win_col = '0;
`endif

endmodule

// File: tb/tb_conv_window_3x3.sv
// Directed self-checking bench for conv_window_3x3 (raster, stride 2, gaps, degenerate, reset).
module tb_conv_window_3x3;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  conv_window_3x3_if bus ();

  conv_window_3x3 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pix(input int r, input int c);
    return 64'(r * 16 + c);
  endfunction

  function automatic logic [WIN_W-1:0] exp_win(input int row, input int col);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*64 +: 64] = pix(row - 2 + r, col - 2 + c);
    return w;
  endfunction

  task automatic step(input logic v, input logic [63:0] r0, input logic [63:0] r1, input logic [63:0] r2);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_row0  = r0;
    bus.in_row1  = r1;
    bus.in_row2  = r2;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int w, input int h, input bit s2, input bit gaps, input bit chg,
                           input int exp_nwin, input int exp_nlast, output logic [WIN_W-1:0] first);
    int  nwin, nlast;
    bit  e, l;
    nwin  = 0;
    nlast = 0;
    first = '0;
    bus.cfg_width   = dim_t'(w);
    bus.cfg_height  = dim_t'(h);
    bus.cfg_stride2 = s2;
    for (int row = 0; row < h; row++) begin
      for (int col = 0; col < w; col++) begin
        if (gaps && $urandom_range(0, 1) == 1) begin
          step(1'b0, 64'h0, 64'h0, 64'h0);
          check("gap_valid", WIN_W'(bus.win_valid), WIN_W'(0));
        end
        if (chg && row == 0 && col == 1) begin
          bus.cfg_width   = dim_t'(w + 3);
          bus.cfg_height  = dim_t'(1);
          bus.cfg_stride2 = ~s2;
        end
        step(1'b1, pix(row, col), pix(row, col) - 64'd16, pix(row, col) - 64'd32);
        e = (w >= 3) && (h >= 3) && (col >= 2) && (row >= 2) &&
            (!s2 || ((col % 2) == 0 && (row % 2) == 0));
        l = e && (row == h - 1) && (col == w - 1);
        check("win_valid", WIN_W'(bus.win_valid), WIN_W'(e));
        check("win_last", WIN_W'(bus.win_last), WIN_W'(l));
        check("busy", WIN_W'(bus.busy), WIN_W'(!((row == h - 1) && (col == w - 1))));
        if (e) begin
          check("win_data", bus.win_data, exp_win(row, col));
`ifdef WIN_COORD_EN
          check("win_row", WIN_W'(bus.win_row), WIN_W'(row - 2));
          check("win_col", WIN_W'(bus.win_col), WIN_W'(col - 2));
`else
          check("win_row", WIN_W'(bus.win_row), WIN_W'(0));
          check("win_col", WIN_W'(bus.win_col), WIN_W'(0));
`endif
          if (nwin == 0) first = bus.win_data;
          nwin++;
          if (l) nlast++;
        end
      end
    end
    step(1'b0, 64'h0, 64'h0, 64'h0);
    check("tail_valid", WIN_W'(bus.win_valid), WIN_W'(0));
    check("n_windows", WIN_W'(nwin), WIN_W'(exp_nwin));
    check("n_last", WIN_W'(nlast), WIN_W'(exp_nlast));
  endtask

  initial begin
    logic [WIN_W-1:0] first;
    logic [WIN_W-1:0] tmp;
    bus.cfg_width   = '0;
    bus.cfg_height  = '0;
    bus.cfg_stride2 = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_row0     = '0;
    bus.in_row1     = '0;
    bus.in_row2     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", WIN_W'(bus.win_valid), WIN_W'(0));
    check("rst_last", WIN_W'(bus.win_last), WIN_W'(0));
    check("rst_busy", WIN_W'(bus.busy), WIN_W'(0));
    check("rst_data", bus.win_data, WIN_W'(0));
    check("rst_row", WIN_W'(bus.win_row), WIN_W'(0));
    check("rst_col", WIN_W'(bus.win_col), WIN_W'(0));
    @(negedge clk);
    rst = 1'b0;

    // Stride 1 raster 4x4: first window spans pixels 0x00..0x22.
    run_frame(4, 4, 1'b0, 1'b0, 1'b0, 4, 1, first);
    tmp = first;
    check("first_00", WIN_W'(tmp[63:0]), WIN_W'(64'h00));
    check("first_22", WIN_W'(tmp[8*64 +: 64]), WIN_W'(64'h22));
    check("first_10", WIN_W'(tmp[3*64 +: 64]), WIN_W'(64'h10));

    // Stride 2 odd dims, then even dims (no last pulse).
    run_frame(5, 5, 1'b1, 1'b0, 1'b0, 4, 1, first);
    run_frame(6, 6, 1'b1, 1'b0, 1'b0, 4, 0, first);

    // Stride 1 with random input gaps.
    run_frame(4, 4, 1'b0, 1'b1, 1'b0, 4, 1, first);
    tmp = first;
    check("gap_first_22", WIN_W'(tmp[8*64 +: 64]), WIN_W'(64'h22));

    // Degenerate width, then mid-frame config change.
    run_frame(2, 8, 1'b0, 1'b0, 1'b0, 0, 0, first);
    run_frame(4, 4, 1'b0, 1'b0, 1'b1, 4, 1, first);

    // Reset after 7 words of a 4x4 frame, then a 3x3 frame.
    bus.cfg_width   = dim_t'(4);
    bus.cfg_height  = dim_t'(4);
    bus.cfg_stride2 = 1'b0;
    for (int i = 0; i < 7; i++)
      step(1'b1, 64'hDEAD_0000 + 64'(i), 64'hBEEF_0000, 64'hCAFE_0000);
    check("pre_rst_busy", WIN_W'(bus.busy), WIN_W'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", WIN_W'(bus.busy), WIN_W'(0));
    check("mid_rst_valid", WIN_W'(bus.win_valid), WIN_W'(0));
    @(negedge clk);
    rst = 1'b0;
    run_frame(3, 3, 1'b0, 1'b0, 1'b0, 1, 1, first);
    tmp = first;
    check("rst3_00", WIN_W'(tmp[63:0]), WIN_W'(64'h00));
    check("rst3_22", WIN_W'(tmp[8*64 +: 64]), WIN_W'(64'h22));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
